tb_mmio_responder: RTL
======================

// Module: tb_mmio_responder
// PURPOSE
//  Responder for the core data-bus MMIO window (EXIT, PRINT, cycle counter, status). Replaces ad-hoc bench decode
//  with a protocol-correct slave that grants, returns r_valid for reads and writes, and buffers PRINT characters.
//  Sits beside the TCDM/stack/periph responders on the cv32e40p data port; address decode upstream drives req_i.
// PARAMETERS
//  BASE_ADDR   32'h8000_0000  MMIO window base; register offsets relative to it
//  FIFO_DEPTH  16             PRINT character FIFO entries (power of 2, >=2)
// PORTS
//  clk_i         in   1   clock, all logic on rising edge
//  rst_i         in   1   synchronous reset, active-high
//  req_i         in   1   request (already decoded to this window)
//  gnt_o         out  1   grant, combinational from req_i/add_i/FIFO state
//  add_i         in   32  byte address
//  wen_i         in   1   1 = read, 0 = write (TCDM convention)
//  be_i          in   4   byte enables
//  data_i        in   32  write data
//  r_data_o      out  32  read data, valid with r_valid_o
//  r_valid_o     out  1   response strobe, one per granted request
//  char_o        out  8   PRINT byte at FIFO head
//  char_valid_o  out  1   FIFO not empty
//  char_ready_i  in   1   consumer pops head when char_valid_o & char_ready_i
//  exit_valid_o  out  1   sticky: EXIT written since reset
//  exit_code_o   out  32  latched EXIT value (0 = pass)
// BEHAVIOUR
//  Reset (rst_i=1 at edge): r_valid_o=0, r_data_o=0, FIFO empty (char_valid_o=0), exit_valid_o=0, exit_code_o=0,
//   cycle counter=0, HI snapshot=0. Reset mid-transaction drops any pending response and all buffered chars.
//  Register map (offset = add_i - BASE_ADDR, add_i[1:0] ignored):
//   0x00 EXIT     W: exit_code_o <= data_i, exit_valid_o <= 1 (first write only; later writes granted, ignored)
//                 R: exit_code_o
//   0x04 PRINT    W: if be_i[0], push data_i[7:0]; be_i[0]=0 -> granted, no push.  R: {24'0, fill level}
//   0x08 CYC_LO   R: counter[31:0]; same edge snapshots counter[63:32] into HI register
//   0x0C CYC_HI   R: HI snapshot (not live counter)
//   0x10 STATUS   R: {30'0, exit_valid_o, fifo_full}
//   other         R: 0; W: no effect; still granted and answered (never hangs the core)
//  Writes to read-only registers: granted, no effect.
//  Handshake: gnt_o = req_i except PRINT write when FIFO full -> gnt_o=0 until a slot frees. Fullness is
//   registered: a pop in the same cycle does NOT enable a push that cycle; grant follows next cycle.
//  Latency: request granted at edge N -> r_valid_o=1 for exactly cycle N+1, r_data_o valid with it (writes
//   return r_data_o=0). Back-to-back granted requests give back-to-back r_valid_o. r_valid_o=0 otherwise.
//  Cycle counter: 64-bit, +1 every cycle out of reset, wraps 2^64-1 -> 0; value read is pre-increment value.
//  FIFO: push when granted PRINT write with be_i[0]; pop on char_valid_o & char_ready_i; simultaneous push+pop
//   when non-empty keeps level; push into empty makes char_valid_o=1 next cycle (no fall-through).
//   Pointers log2(FIFO_DEPTH)+1 bits, wrap naturally; full = MSB differ & rest equal.
//  Read of PRINT level reflects level before this cycle's push/pop.
// STRUCTURE
//  tb_mmio_pkg: register offset localparams (MMIO_EXIT/PRINT/CYC_LO/CYC_HI/STATUS), typedef enum mmio_reg_e
//   for decoded target, STATUS bit indices.
//  Sub-module tb_mmio_char_fifo #(WIDTH=8, DEPTH): sync FIFO, push/pop/full/empty/level, reset rst_i.
//  Top: combinational decode -> grant -> one response pipeline register (r_valid, r_data), EXIT/HI/counter regs.
// TESTING
//  Write 0x0000_0000 to 0x8000_0000 -> gnt same cycle, r_valid next cycle, exit_valid_o=1, exit_code_o=0; second
//   write 0x5 -> exit_code_o stays 0.
//  char_ready_i=0, 17 PRINT writes 'A'..'Q' (depth 16) -> 16 granted, 17th gnt_o=0; raise char_ready_i one
//   cycle -> char_o='A' popped, 17th granted next cycle; drain yields 'B'..'Q' in order.
//  PRINT write with be_i=4'b1110 -> granted, r_valid_o=1, level unchanged, char_valid_o stays 0.
//  Force counter to 0x0000_0000_FFFF_FFFF, read CYC_LO then CYC_HI -> 0xFFFF_FFFF then 0x0 (snapshot), next
//   LO/HI pair -> small LO, HI=0x1.
//  Back-to-back reads STATUS, unmapped 0x8000_0100, EXIT -> three consecutive r_valid_o, data 0x0/0x0/exit code.
//  Assert rst_i with 3 chars buffered and a response pending -> next cycle r_valid_o=0, char_valid_o=0, exit cleared.

Source files
------------

// File: rtl/tb_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_pkg
//  Description : Shared definitions for the MMIO responder. Holds the
//                register offsets, the decoded-target enum, the STATUS bit
//                positions and the offset decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package tb_mmio_pkg;

    // Register offsets relative to the MMIO window base
    localparam logic [31:0] MMIO_EXIT   = 32'h0000_0000;
    localparam logic [31:0] MMIO_PRINT  = 32'h0000_0004;
    localparam logic [31:0] MMIO_CYC_LO = 32'h0000_0008;
    localparam logic [31:0] MMIO_CYC_HI = 32'h0000_000C;
    localparam logic [31:0] MMIO_STATUS = 32'h0000_0010;

    // STATUS register bit positions
    localparam int STATUS_FULL_BIT = 0;
    localparam int STATUS_EXIT_BIT = 1;

    // Decoded register target of the current access
    typedef enum logic [2:0] {
        REG_EXIT   = 3'd0,
        REG_PRINT  = 3'd1,
        REG_CYC_LO = 3'd2,
        REG_CYC_HI = 3'd3,
        REG_STATUS = 3'd4,
        REG_NONE   = 3'd5
    } mmio_reg_e;

    // Map a window offset to a register; the byte lane bits are ignored so
    // any byte address inside a word selects that word.
    function automatic mmio_reg_e mmio_decode(input logic [31:0] offset);
        logic [31:0] word_off;
        mmio_reg_e   target;
        word_off = {offset[31:2], 2'b00};
        case (word_off)
            MMIO_EXIT:   target = REG_EXIT;
            MMIO_PRINT:  target = REG_PRINT;
            MMIO_CYC_LO: target = REG_CYC_LO;
            MMIO_CYC_HI: target = REG_CYC_HI;
            MMIO_STATUS: target = REG_STATUS;
            default:     target = REG_NONE;
        endcase
        return target;
    endfunction

endpackage
`default_nettype wire

// File: rtl/tb_mmio_char_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_char_fifo
//  Description : Synchronous FIFO buffering PRINT characters. Registered
//                read side (no fall-through), extra pointer MSB to tell
//                full from empty, level derived from pointer difference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_char_fifo
    import tb_mmio_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    // Storage is not reset: an entry is only observable after it was pushed
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A depth that is not a power of two would break the natural wrap
    if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
        $error("tb_mmio_char_fifo: DEPTH must be a power of two and >= 2");
    end

    // Guard both ports so a misbehaving caller cannot corrupt the pointers
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // Same index bits and same wrap bit means no entries; wrap bits
    // differing with equal index bits means every slot is occupied.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                   (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign level = wr_ptr - rd_ptr;
    assign rdata = mem[rd_ptr[AW-1:0]];

    // Write the incoming character into the slot addressed by the write pointer
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

    // Advance the pointers; reset empties the FIFO and drops buffered data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/tb_mmio_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_responder
//  Description : Data-bus slave for the simulation MMIO window: EXIT code
//                latch, PRINT character FIFO, 64-bit cycle counter with
//                snapshot-on-low-read, and STATUS. Every granted request
//                gets exactly one r_valid_o the following cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_responder
    import tb_mmio_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] data_i,
    output logic [31:0] r_data_o,
    output logic        r_valid_o,
    output logic [7:0]  char_o,
    output logic        char_valid_o,
    input  logic        char_ready_i,
    output logic        exit_valid_o,
    output logic [31:0] exit_code_o
);

    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;

    logic [31:0]      offset;
    mmio_reg_e        target;
    logic             is_read;
    logic             is_print_wr;
    logic             granted;
    logic             fifo_push;
    logic             fifo_pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [LVL_W-1:0] fifo_level;
    logic [63:0]      cyc_cnt;
    logic [31:0]      hi_snap;
    logic [31:0]      status_word;
    logic [31:0]      read_word;
    logic             unused_be;

    // Only byte lane 0 matters (PRINT push qualifier)
    assign unused_be = ^be_i[3:1];

    // Address decode relative to the window base
    assign offset  = add_i - BASE_ADDR;
    assign target  = mmio_decode(offset);
    assign is_read = wen_i;

    // Only a PRINT write into a full FIFO is ever stalled. Fullness comes
    // from registered pointers, so a pop this cycle frees the slot for the
    // next cycle rather than this one.
    assign is_print_wr = req_i & ~is_read & (target == REG_PRINT);
    assign gnt_o       = req_i & ~(is_print_wr & fifo_full);
    assign granted     = gnt_o;

    assign fifo_push    = granted & is_print_wr & be_i[0];
    assign fifo_pop     = char_valid_o & char_ready_i;
    assign char_valid_o = ~fifo_empty;

    tb_mmio_char_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_char_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .wdata (data_i[7:0]),
        .pop   (fifo_pop),
        .rdata (char_o),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    // Assemble STATUS from the live exit flag and registered FIFO fullness
    always_comb begin
        status_word                  = '0;
        status_word[STATUS_FULL_BIT] = fifo_full;
        status_word[STATUS_EXIT_BIT] = exit_valid_o;
    end

    // Read data mux; writes and unmapped reads answer with zero
    always_comb begin
        read_word = '0;
        if (is_read) begin
            case (target)
                REG_EXIT:   read_word = exit_code_o;
                REG_PRINT:  read_word = 32'(fifo_level);
                REG_CYC_LO: read_word = cyc_cnt[31:0];
                REG_CYC_HI: read_word = hi_snap;
                REG_STATUS: read_word = status_word;
                default:    read_word = '0;
            endcase
        end
    end

    // Single response stage: one strobe per grant, exactly one cycle later
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_valid_o <= 1'b0;
            r_data_o  <= '0;
        end else begin
            r_valid_o <= granted;
            r_data_o  <= granted ? read_word : 32'h0;
        end
    end

    // Latch only the first EXIT write; later writes are accepted but ignored
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            exit_valid_o <= 1'b0;
            exit_code_o  <= '0;
        end else if (granted && !is_read && (target == REG_EXIT) && !exit_valid_o) begin
            exit_valid_o <= 1'b1;
            exit_code_o  <= data_i;
        end
    end

    // Free-running 64-bit cycle counter, wraps naturally
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cyc_cnt <= '0;
        end else begin
            cyc_cnt <= cyc_cnt + 64'd1;
        end
    end

    // Capture the upper half when the lower half is read so a LO/HI pair is coherent
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hi_snap <= '0;
        end else if (granted && is_read && (target == REG_CYC_LO)) begin
            hi_snap <= cyc_cnt[63:32];
        end
    end

endmodule
`default_nettype wire
